// File: rtl/shft_pipe_if.sv
// Operand/result handshake bundle for shft_pipe.
// slave = the shifter, master = its producer/consumer.
interface shft_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_cnt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );
endinterface

// File: rtl/shft_pipe.sv
// Pipelined log barrel shifter/rotator with valid/ready on both sides.
// Define SHFT_PIPE_ROTATE_EN to implement ROL/ROR; otherwise they pass the operand through.
module shft_pipe #(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2
) (
    input logic       clk,
    input logic       rst_n,
    shft_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int LPS   = (CNT_W + PIPE - 1) / PIPE;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic [2:0]       mode;
        logic             carry;
    } stg_t;

    // One mux level: shift by 2^k. Carry is the last bit pushed out by this level,
    // so the highest applied level leaves the overall last-out bit behind.
    function automatic stg_t lvl(input stg_t s, input int k);
        stg_t             r;
        logic [WIDTH-1:0] tmp;
        int               sh;
        r   = s;
        sh  = 1 << k;
        tmp = '0;
        case (s.mode)
            3'b000: begin
                r.data  = s.data << sh;
                tmp     = s.data >> (WIDTH - sh);
                r.carry = tmp[0];
            end
            3'b001: begin
                r.data  = s.data >> sh;
                tmp     = s.data >> (sh - 1);
                r.carry = tmp[0];
            end
            3'b010: begin
                r.data  = $signed(s.data) >>> sh;
                tmp     = s.data >> (sh - 1);
                r.carry = tmp[0];
            end
`ifdef SHFT_PIPE_ROTATE_EN
            3'b011: begin
                r.data  = (s.data << sh) | (s.data >> (WIDTH - sh));
                r.carry = r.data[0];
            end
            3'b100: begin
                r.data  = (s.data >> sh) | (s.data << (WIDTH - sh));
                r.carry = r.data[WIDTH-1];
            end
`endif
            default: ;
        endcase
        return r;
    endfunction

    logic [PIPE-1:0]   vld_q;
    logic [PIPE:0]     vld_pipe;
    logic [PIPE-1:0]   ld;
    stg_t              stg_in;
    stg_t [PIPE-1:0]   stg_q;
    stg_t [PIPE-1:0]   stg_d;
    stg_t [PIPE:0]     stg_s;
    logic              zero_q;

    assign stg_in   = '{data: bus.in_data, cnt: bus.in_cnt, mode: bus.in_mode, carry: 1'b0};
    assign stg_s    = {stg_q, stg_in};
    assign vld_pipe = {vld_q, bus.in_valid};

    // A stage may load if any stage downstream of it (inclusive) has a hole,
    // or the consumer is draining the tail this cycle.
    for (genvar j = 0; j < PIPE; j++) begin : g_ld
        assign ld[j] = bus.out_ready || !(&vld_q[PIPE-1:j]);
    end

    always_comb begin
        stg_d = '0;
        for (int j = 0; j < PIPE; j++) begin
            stg_d[j] = stg_s[j];
            for (int k = j * LPS; k < CNT_W && k < (j + 1) * LPS; k++) begin
                if (stg_s[j].cnt[k]) stg_d[j] = lvl(stg_d[j], k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            stg_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            for (int j = 0; j < PIPE; j++) begin
                if (ld[j]) begin
                    vld_q[j] <= vld_pipe[j];
                    if (vld_pipe[j]) stg_q[j] <= stg_d[j];
                end
            end
            if (ld[PIPE-1] && vld_pipe[PIPE-1])
                zero_q <= (stg_d[PIPE-1].data == '0);
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld_q[PIPE-1];
    assign bus.out_data  = stg_q[PIPE-1].data;
    assign bus.out_carry = stg_q[PIPE-1].carry;
    assign bus.out_zero  = zero_q;
endmodule

// File: doc/shft_pipe.md
# shft_pipe

Parametrised, pipelined barrel shifter/rotator for the execute stage. Takes a WIDTH-bit operand, a shift count and a mode, and produces the shifted result plus carry-out and zero flags after a fixed PIPE-cycle latency. Uses a valid/ready handshake on both sides, so it can stall without losing or reordering operations. Replaces the fixed 16-bit, left-only, purely combinational shifter.

## Interface
- WIDTH, 16, operand width; power of two, ≥ 4
- PIPE, 2, register stages; 1 ≤ PIPE ≤ CNT_W, where CNT_W = $clog2(WIDTH) is a derived localparam
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset; assertion clears state immediately, deassertion is synchronous to clk
- in_valid  in  1  input operation present
- in_ready  out  1  block can accept an input this cycle
- in_data  in  WIDTH  operand
- in_cnt  in  CNT_W  shift amount, 0..WIDTH-1
- in_mode  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 reserved
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result this cycle
- out_data  out  WIDTH  result
- out_carry  out  1  last bit shifted or rotated out
- out_zero  out  1  out_data == 0

## Operation
- Log-shifter: CNT_W mux levels. Level k shifts by 2^k when in_cnt[k]=1.
- Levels are split across PIPE stages at ceil(CNT_W/PIPE) levels per stage. The last stage may hold fewer levels.
- Each stage registers: valid, partial data, remaining count bits, mode, and running carry.
- Fill rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the operand MSB.
  - ROL and ROR fill with the wrapped bits.
- out_carry rules:
  - in_cnt = 0: 0.
  - SLL: in_data[WIDTH-cnt].
  - SRL and SRA: in_data[cnt-1].
  - ROL: out_data[0].
  - ROR: out_data[WIDTH-1].
- Reserved modes: out_data = in_data, out_carry = 0.
- out_zero is computed from the final out_data and registered with it.
- Handshake:
  - A transfer occurs when valid && ready are both high on a rising edge.
  - Stage k loads when it is empty or stage k+1 (or the consumer) is taking its contents.
  - in_ready = stage-0 load condition. A combinational path from out_ready to in_ready is permitted.
  - out_valid, out_data, out_carry and out_zero hold stable while out_valid && !out_ready.
- Order is preserved. There is no drop and no duplication.

## Timing
- Latency: a transfer accepted at edge N gives out_valid at edge N+PIPE, provided there is no backpressure.
- Throughput: 1 operation per cycle while out_ready stays high.
- Capacity: PIPE operations in flight. With out_ready low, in_ready falls after PIPE accepts.
- Simultaneous accept and drain when full: allowed. Throughput is sustained and no bubble is inserted.
- Reset values: every stage valid = 0, out_valid = 0, out_data = 0, out_carry = 0, out_zero = 0, in_ready = 1 (from the first cycle after deassertion).
- Reset mid-flight:
  - All in-flight operations are discarded.
  - No out_valid appears until a new accept plus PIPE cycles.
- Changing in_* while in_valid && !in_ready: ignored. The block samples inputs only on a transfer.

## Configuration
- SHFT_PIPE_ROTATE_EN defined: ROL (011) and ROR (100) are implemented as above.
- SHFT_PIPE_ROTATE_EN undefined:
  - 011 and 100 are treated as reserved: out_data = in_data, out_carry = 0.
  - The rotate wrap muxing is removed.
  - Latency and handshake are unchanged.

## Test plan
- SLL 0x1234 cnt 4 (WIDTH 16, PIPE 2) -> out_data 0x2340, out_carry 1, out_zero 0, out_valid exactly 2 cycles after accept.
- SRA 0x8001 cnt 15 -> 0xFFFF, carry 0. SRL 0x8001 cnt 1 -> 0x4000, carry 1. SLL 0x8000 cnt 1 -> 0x0000, carry 1, zero 1. Any mode cnt 0 on 0xA5A5 -> 0xA5A5, carry 0.
- ROR 0x0001 cnt 1 -> 0x8000, carry 1; ROL 0x8001 cnt 4 -> 0x0018, carry 0. With the macro undefined, both return the operand unchanged with carry 0. Mode 111 -> pass-through, carry 0.
- Hold out_ready low while offering 4 back-to-back ops -> in_ready falls after 2 accepts and outputs stay stable. On release, all 4 results arrive in order with no loss, then 1 per cycle.
- Stream 8 ops with out_ready held high -> 8 consecutive out_valid cycles, no bubbles, results match the reference model.
- Assert rst_n low asynchronously with 2 ops in flight -> out_valid = 0 immediately. After deassertion, no output until a new op is accepted, then that op's result appears at accept+2.
